connection_transmitter_master: RTL and testbench

//  Return path of the UART-to-APB bridge: serialises each completed APB transfer into a byte frame for the UART transmitter.

---
 rtl/connection_transmitter_master.sv | 85 ++++++++
 tb/tb_connection_transmitter_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/connection_transmitter_master.sv
// UART-to-APB bridge return path: turns each completed APB transfer into a
// status byte (plus prdata bytes, MSB first, for reads) handed to the UART TX.
module connection_transmitter_master #(
  parameter logic [3:0] HDR        = 4'hA,
  parameter int         DATA_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rsp_valid,
  input  logic        rsp_write,
  input  logic        rsp_err,
  input  logic [31:0] rsp_rdata,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, SEND, ACK, DRAIN} state_t;

  localparam logic [2:0] READ_LEN = 3'(DATA_BYTES + 1);

  state_t      state;
  logic [39:0] shreg;   // {status, rdata}; the byte on deck is always [39:32]
  logic [2:0]  count;
  logic [2:0]  length;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx_start   <= 1'b0;
      tx_byte    <= 8'h00;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      shreg      <= '0;
      count      <= '0;
      length     <= '0;
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      // Only one response in flight; anything arriving outside IDLE is lost.
      if (rsp_valid && state != IDLE)
        overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (rsp_valid) begin
            shreg  <= {HDR, 2'b00, rsp_err, rsp_write, rsp_rdata};
            length <= rsp_write ? 3'd1 : READ_LEN;
            count  <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_byte  <= shreg[39:32];
            shreg    <= {shreg[31:0], 8'h00};
            state    <= ACK;
          end
        end
        ACK: begin
          if (tx_busy)
            state <= DRAIN;
        end
        DRAIN: begin
          if (!tx_busy) begin
            count <= count + 3'd1;
            if (count + 3'd1 == length) begin
              state      <= IDLE;
              frame_done <= 1'b1;
            end else begin
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_connection_transmitter_master.sv
// Self-checking bench: a UART model captures every transmitted byte and each
// frame is compared with one built from the status/byte-order rules.
module tb_connection_transmitter_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        rsp_valid, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        busy, frame_done, overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  connection_transmitter_master dut (
    .clk(clk), .rst(rst), .rsp_valid(rsp_valid), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_byte(tx_byte), .busy(busy),
    .frame_done(frame_done), .overflow(overflow)
  );

  // UART model: busy for busy_len cycles after each accepted start
  logic [7:0] cap[$];
  int         fd_cnt   = 0;
  int         busy_len = 10;
  int         ucnt     = 0;
  logic       ubusy    = 1'b0;
  logic       hold_busy = 1'b0;
  assign tx_busy = ubusy | hold_busy;

  always @(posedge clk) begin
    if (tx_start) begin
      cap.push_back(tx_byte);
      ucnt  <= busy_len;
      ubusy <= 1'b1;
    end else if (ucnt > 1) begin
      ucnt <= ucnt - 1;
    end else begin
      ucnt  <= 0;
      ubusy <= 1'b0;
    end
    if (frame_done) fd_cnt++;
  end

  // Reference frame from the rules: status, then prdata bytes MSB first.
  function automatic void model_frame(input logic w, input logic e,
                                      input logic [31:0] d, output logic [7:0] q[$]);
    q = {};
    q.push_back({4'hA, 2'b00, e, w});
    if (!w)
      for (int i = 3; i >= 0; i--) q.push_back(8'((d >> (8 * i)) & 32'hFF));
  endfunction

  task automatic send_rsp(input logic w, input logic e, input logic [31:0] d);
    @(negedge clk);
    rsp_valid = 1'b1; rsp_write = w; rsp_err = e; rsp_rdata = d;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_rdata = $urandom;
  endtask

  task automatic wait_frame(input int limit, input string name);
    int n = 0;
    while (frame_done !== 1'b1 && n < limit) begin @(negedge clk); n++; end
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL %s frame_done timeout: got %b want 1", name, frame_done);
    end
  endtask

  task automatic wait_idle_uart();
    int n = 0;
    while (tx_busy && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_valid = 0; rsp_write = 0; rsp_err = 0; rsp_rdata = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_start, tx_byte, busy, frame_done, overflow} !== 12'h000) begin
      bad++;
      $display("FAIL reset outputs: got %h want 000", {tx_start, tx_byte, busy, frame_done, overflow});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [7:0] exp[$];
    cap = {}; fd_cnt = 0; busy_len = 10;
    model_frame(1'b0, 1'b0, 32'hDEADBEEF, exp);
    @(negedge clk);
    rsp_valid = 1; rsp_write = 0; rsp_err = 0; rsp_rdata = 32'hDEADBEEF;
    @(negedge clk);
    rsp_valid = 0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL read busy after rsp: got %b want 1", busy); end
    wait_frame(400, "read");
    repeat (20) @(negedge clk);
    total++;
    if (cap.size() != 5) begin bad++; $display("FAIL read byte count: got %0d want 5", cap.size()); end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      total++;
      if (cap[i] !== exp[i]) begin bad++; $display("FAIL read byte %0d: got %h want %h", i, cap[i], exp[i]); end
    end
    total++;
    if (fd_cnt != 1) begin bad++; $display("FAIL read frame_done count: got %0d want 1", fd_cnt); end
  endtask

  task automatic test_write_err();
    cap = {}; fd_cnt = 0; busy_len = 6;
    send_rsp(1'b1, 1'b1, 32'h12345678);
    wait_frame(200, "write_err");
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL write_err busy at done: got %b want 0", busy); end
    repeat (20) @(negedge clk);
    total++;
    if (cap.size() != 1 || cap[0] !== 8'hA3) begin
      bad++; $display("FAIL write_err frame: got n=%0d b0=%h want n=1 b0=a3", cap.size(), cap.size() ? cap[0] : 8'h00);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp[$];
    logic [31:0] d = $urandom;
    int n = 0;
    cap = {}; fd_cnt = 0; busy_len = 8;
    model_frame(1'b0, 1'b0, d, exp);
    send_rsp(1'b0, 1'b0, d);
    while (cap.size() < 2 && n < 200) begin @(negedge clk); n++; end
    send_rsp(1'b1, 1'b1, 32'hFFFFFFFF);
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL overflow flag: got %b want 1", overflow); end
    wait_frame(400, "overflow");
    repeat (30) @(negedge clk);
    total++;
    if (cap.size() != exp.size()) begin bad++; $display("FAIL overflow byte count: got %0d want %0d", cap.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      total++;
      if (cap[i] !== exp[i]) begin bad++; $display("FAIL overflow byte %0d: got %h want %h", i, cap[i], exp[i]); end
    end
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL overflow sticky: got %b want 1", overflow); end
  endtask

  task automatic test_busy_at_start();
    logic [7:0] exp[$];
    cap = {}; fd_cnt = 0; busy_len = 5;
    model_frame(1'b0, 1'b0, 32'h01020304, exp);
    hold_busy = 1'b1;
    send_rsp(1'b0, 1'b0, 32'h01020304);
    repeat (20) @(negedge clk);
    total++;
    if (cap.size() != 0 || busy !== 1'b1) begin
      bad++; $display("FAIL busy_at_start withheld: got n=%0d busy=%b want n=0 busy=1", cap.size(), busy);
    end
    hold_busy = 1'b0;
    wait_frame(400, "busy_at_start");
    repeat (10) @(negedge clk);
    total++;
    if (cap.size() != exp.size()) begin bad++; $display("FAIL busy_at_start count: got %0d want %0d", cap.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      total++;
      if (cap[i] !== exp[i]) begin bad++; $display("FAIL busy_at_start byte %0d: got %h want %h", i, cap[i], exp[i]); end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp[$];
    int n = 0;
    cap = {}; fd_cnt = 0; busy_len = 10;
    send_rsp(1'b0, 1'b0, 32'hCAFEF00D);
    while (cap.size() < 3 && n < 300) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);  // byte 3 on the line: DRAIN
    #2 rst = 1'b1;
    #1;
    total++;
    if ({tx_start, busy, overflow} !== 3'b000) begin
      bad++; $display("FAIL mid_reset outputs: got %b want 000", {tx_start, busy, overflow});
    end
    @(negedge clk);
    rst = 1'b0;
    wait_idle_uart();
    total++;
    if (cap.size() != 3 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset no resume: got n=%0d busy=%b want n=3 busy=0", cap.size(), busy);
    end
    cap = {};
    model_frame(1'b0, 1'b0, 32'h89ABCDEF, exp);
    send_rsp(1'b0, 1'b0, 32'h89ABCDEF);
    wait_frame(400, "mid_reset");
    repeat (15) @(negedge clk);
    total++;
    if (cap.size() != exp.size()) begin bad++; $display("FAIL mid_reset count: got %0d want %0d", cap.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      total++;
      if (cap[i] !== exp[i]) begin bad++; $display("FAIL mid_reset byte %0d: got %h want %h", i, cap[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    logic [7:0] e2[$];
    logic [31:0] d2 = $urandom;
    cap = {}; fd_cnt = 0; busy_len = 3;
    model_frame(1'b1, 1'b0, 32'h0, exp);
    model_frame(1'b0, 1'b1, d2, e2);
    foreach (e2[i]) exp.push_back(e2[i]);
    send_rsp(1'b1, 1'b0, 32'h0);
    wait_frame(200, "back_to_back first");
    rsp_valid = 1; rsp_write = 0; rsp_err = 1; rsp_rdata = d2;
    @(negedge clk);
    rsp_valid = 0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL back_to_back accepted: got busy=%b want 1", busy); end
    wait_frame(400, "back_to_back second");
    repeat (10) @(negedge clk);
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL back_to_back overflow: got %b want 0", overflow); end
    total++;
    if (cap.size() != exp.size()) begin bad++; $display("FAIL back_to_back count: got %0d want %0d", cap.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      total++;
      if (cap[i] !== exp[i]) begin bad++; $display("FAIL back_to_back byte %0d: got %h want %h", i, cap[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] exp[$];
      logic w = 1'($urandom);
      logic e = 1'($urandom);
      logic [31:0] d = $urandom;
      cap = {}; fd_cnt = 0; busy_len = $urandom_range(1, 6);
      model_frame(w, e, d, exp);
      send_rsp(w, e, d);
      wait_frame(300, "random");
      repeat (8) @(negedge clk);
      total++;
      if (cap.size() != exp.size() || fd_cnt != 1) begin
        bad++; $display("FAIL random %0d count: got n=%0d fd=%0d want n=%0d fd=1", k, cap.size(), fd_cnt, exp.size());
      end
      for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
        total++;
        if (cap[i] !== exp[i]) begin bad++; $display("FAIL random %0d byte %0d: got %h want %h", k, i, cap[i], exp[i]); end
      end
    end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL random overflow: got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_err();
    test_overflow();
    test_busy_at_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
